// File: rtl/lake_harness_pkg.sv
// Shared types and helpers for the lake port harness.
// No logic: state encoding, checksum width, packed-bus slicing.
// No flow control.
package lake_harness_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int CHK_WIDTH = 32;

    // Low bit index of channel ch inside a packed bus of width-wide lanes.
    function automatic int chan_slice(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

// File: rtl/lake_capture_buf.sv
// Per-channel capture memory: one write port, one read-first read port.
// Read latency 1 cycle; rd_data holds while rd_en is low.
// No backpressure: writes and reads are accepted every cycle.
module lake_capture_buf
    import lake_harness_pkg::*;
#(
    parameter  int DATA_WIDTH = 16,
    parameter  int DEPTH      = 1024,
    localparam int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Both ports update on the same edge, so a colliding read sees the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/lake_port_harness.sv
// Stimulus/capture harness: flushes the DUT, drives affine ramps, captures outputs.
// Stimulus is registered; readback has 1-cycle latency.
// No backpressure: the DUT is assumed to accept one sample per cycle in RUN.
module lake_port_harness
    import lake_harness_pkg::*;
#(
    parameter  int DATA_WIDTH   = 16,
    parameter  int NUM_IN       = 1,
    parameter  int NUM_OUT      = 1,
    parameter  int DEPTH        = 1024,
    parameter  int FLUSH_CYCLES = 4,
    parameter  int CNT_WIDTH    = 32,
    localparam int CW           = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1,
    localparam int AW           = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int RAW          = $clog2(DEPTH) + 1,
    localparam int FW           = $clog2(FLUSH_CYCLES + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [CNT_WIDTH-1:0]           cfg_num_cycles,
    input  logic [NUM_IN*DATA_WIDTH-1:0]   cfg_ramp_start,
    input  logic [NUM_IN*DATA_WIDTH-1:0]   cfg_ramp_stride,
    output logic                           flush,
    output logic [NUM_IN*DATA_WIDTH-1:0]   port_in_data,
    input  logic [NUM_OUT*DATA_WIDTH-1:0]  port_out_data,
    input  logic                           rd_en,
    input  logic [CW-1:0]                  rd_chan,
    input  logic [RAW-1:0]                 rd_addr,
    output logic [DATA_WIDTH-1:0]          rd_data,
    output logic                           rd_valid,
    output logic [NUM_OUT*CHK_WIDTH-1:0]   checksum,
    output logic [63:0]                    cycle_count,
    output logic                           busy,
    output logic                           done,
    output logic                           overflow
);

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  num_q;
    logic [CNT_WIDTH-1:0]  run_cnt_q;
    logic [FW-1:0]         flush_cnt_q;
    logic [DATA_WIDTH-1:0] base_q   [NUM_IN];
    logic [DATA_WIDTH-1:0] stride_q [NUM_IN];
    logic [DATA_WIDTH-1:0] ramp_q   [NUM_IN];
    logic [CHK_WIDTH-1:0]  chk_q    [NUM_OUT];
    logic [DATA_WIDTH-1:0] buf_rd   [NUM_OUT];

    logic start_acc;
    logic flush_last;
    logic run_last;
    logic in_range;
    logic wr_en;
    logic rd_in_range;
    logic rd_ok_q;
    logic [CW-1:0] rd_chan_q;

    assign start_acc  = start && ((state_q == IDLE) || (state_q == DONE));
    assign flush_last = (state_q == FLUSH) && (flush_cnt_q == FW'(FLUSH_CYCLES - 1));
    assign run_last   = (state_q == RUN) && (run_cnt_q == (num_q - CNT_WIDTH'(1)));
    // DEPTH is a power of two, so "k < DEPTH" is "no bits above the address".
    assign in_range   = ((run_cnt_q >> AW) == '0);
    assign wr_en      = (state_q == RUN) && in_range && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start) state_d = FLUSH;
            FLUSH: if (flush_last) state_d = (num_q == '0) ? DONE : RUN;
            RUN:   if (run_last) state_d = DONE;
            DONE:  if (start) state_d = FLUSH;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        flush = (state_q == FLUSH);
        busy  = (state_q == FLUSH) || (state_q == RUN);
        done  = (state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            num_q       <= '0;
            run_cnt_q   <= '0;
            flush_cnt_q <= '0;
            cycle_count <= '0;
            overflow    <= 1'b0;
            for (int ch = 0; ch < NUM_IN; ch++) begin
                base_q[ch]   <= '0;
                stride_q[ch] <= '0;
                ramp_q[ch]   <= '0;
            end
            for (int ch = 0; ch < NUM_OUT; ch++) begin
                chk_q[ch] <= '0;
            end
        end else begin
            flush_cnt_q <= (state_q == FLUSH) ? flush_cnt_q + 1'b1 : '0;
            run_cnt_q   <= (state_q == RUN) ? run_cnt_q + 1'b1 : '0;

            if (start_acc) begin
                num_q <= cfg_num_cycles;
            end

            for (int ch = 0; ch < NUM_IN; ch++) begin
                if (start_acc) begin
                    base_q[ch]   <= cfg_ramp_start[chan_slice(ch, DATA_WIDTH) +: DATA_WIDTH];
                    stride_q[ch] <= cfg_ramp_stride[chan_slice(ch, DATA_WIDTH) +: DATA_WIDTH];
                end
                // Accumulate through RUN; snap back to the base on the last cycle.
                if ((state_q == RUN) && !run_last) begin
                    ramp_q[ch] <= ramp_q[ch] + stride_q[ch];
                end else if (start_acc) begin
                    ramp_q[ch] <= cfg_ramp_start[chan_slice(ch, DATA_WIDTH) +: DATA_WIDTH];
                end else begin
                    ramp_q[ch] <= base_q[ch];
                end
            end

            if (start_acc) begin
                cycle_count <= '0;
                overflow    <= 1'b0;
                for (int ch = 0; ch < NUM_OUT; ch++) begin
                    chk_q[ch] <= '0;
                end
            end else if (state_q == RUN) begin
                cycle_count <= cycle_count + 64'd1;
                if (!in_range) begin
                    overflow <= 1'b1;
                end
                for (int ch = 0; ch < NUM_OUT; ch++) begin
                    chk_q[ch] <= chk_q[ch]
                        + CHK_WIDTH'(port_out_data[chan_slice(ch, DATA_WIDTH) +: DATA_WIDTH]);
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_IN; g++) begin : g_in
        assign port_in_data[chan_slice(g, DATA_WIDTH) +: DATA_WIDTH] = ramp_q[g];
    end

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
        assign checksum[chan_slice(g, CHK_WIDTH) +: CHK_WIDTH] = chk_q[g];

        lake_capture_buf #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH)
        ) u_buf (
            .clk     (clk),
            .wr_en   (wr_en),
            .wr_addr (run_cnt_q[AW-1:0]),
            .wr_data (port_out_data[chan_slice(g, DATA_WIDTH) +: DATA_WIDTH]),
            .rd_en   (rd_en),
            .rd_addr (rd_addr[AW-1:0]),
            .rd_data (buf_rd[g])
        );
    end

    assign rd_in_range = !rd_addr[RAW-1] && (int'(rd_chan) < NUM_OUT);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid  <= 1'b0;
            rd_ok_q   <= 1'b0;
            rd_chan_q <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_ok_q   <= rd_in_range;
                rd_chan_q <= rd_chan;
            end
        end
    end

    // Out-of-range requests, and the time before any read, return zero.
    always_comb begin
        rd_data = '0;
        if (rd_ok_q) begin
            for (int ch = 0; ch < NUM_OUT; ch++) begin
                if (rd_chan_q == CW'(ch)) begin
                    rd_data = buf_rd[ch];
                end
            end
        end
    end

endmodule

// File: doc/lake_port_harness.md
Name: lake_port_harness

Overview:
- Synthesizable stimulus and capture harness that wraps a lakespec-style DUT for FPGA and emulation bring-up.
- Sequences the DUT flush, then drives NUM_IN input ports with per-channel affine ramps (start + stride*k).
- Captures NUM_OUT output ports into on-chip buffers and keeps a cycle counter and per-channel checksums.
- Host reads results back through a simple read port; this replaces file-based testbench capture.

Parameters:
DATA_WIDTH, 16, width of every DUT data port
NUM_IN, 1, number of driven DUT input ports (>=1)
NUM_OUT, 1, number of captured DUT output ports (>=1)
DEPTH, 1024, capture entries per output channel (power of two)
FLUSH_CYCLES, 4, cycles flush is held high before RUN (>=1)
CNT_WIDTH, 32, width of run-length configuration and counters

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  single-cycle pulse; begins a run from IDLE or DONE
cfg_num_cycles  in  CNT_WIDTH  RUN length N; sampled on accepted start
cfg_ramp_start  in  NUM_IN*DATA_WIDTH  per-channel ramp base; sampled on start
cfg_ramp_stride  in  NUM_IN*DATA_WIDTH  per-channel ramp step; sampled on start
flush  out  1  DUT flush
port_in_data  out  NUM_IN*DATA_WIDTH  DUT input stimulus
port_out_data  in  NUM_OUT*DATA_WIDTH  DUT output samples
rd_en  in  1  readback request
rd_chan  in  $clog2(NUM_OUT) (min 1)  readback channel
rd_addr  in  $clog2(DEPTH)+1  readback index
rd_data  out  DATA_WIDTH  readback data, 1-cycle latency
rd_valid  out  1  high the cycle after rd_en
checksum  out  NUM_OUT*32  per-channel sum of captured samples mod 2^32
cycle_count  out  64  RUN cycles elapsed in current/last run
busy  out  1  state is FLUSH or RUN
done  out  1  state is DONE
overflow  out  1  N > DEPTH in last run (samples beyond DEPTH dropped)

Behaviour:
- Reset: every output is 0, state IDLE, configuration registers cleared. Buffer contents are not cleared.
- FSM states: IDLE, FLUSH, RUN, DONE.
  - IDLE -> FLUSH on start.
  - FLUSH lasts exactly FLUSH_CYCLES cycles; flush=1 only in FLUSH.
  - FLUSH -> RUN if N>0; FLUSH -> DONE if N==0.
  - RUN lasts exactly N cycles, then -> DONE.
  - DONE holds until start (-> FLUSH) or rst.
- start in FLUSH or RUN: ignored; configuration is not resampled.
- start in DONE: clears cycle_count, checksum and overflow in the same edge that enters FLUSH.
- Stimulus:
  - In RUN cycle k (k=0..N-1), port_in_data[ch] = start[ch] + stride[ch]*k mod 2^DATA_WIDTH.
  - Implemented as a registered accumulator, not a multiplier.
  - Outside RUN, port_in_data holds the ramp base value.
- Capture:
  - On the clock edge ending RUN cycle k, the port_out_data sample is written to buf[ch][k] if k<DEPTH.
  - The same sample is added to checksum[ch] for every k, including k>=DEPTH.
  - overflow is set on the first dropped sample.
- cycle_count increments once per RUN cycle; it equals N in DONE.
- Readback:
  - Allowed in any state. Read-first: same-cycle write and read to one address returns the old data.
  - rd_addr>=DEPTH or rd_chan>=NUM_OUT returns 0 with rd_valid=1.
  - rd_data holds its value when rd_en=0.
- rst mid-run: returns to IDLE next edge and drops flush. Partial buffer contents remain readable.
- Arithmetic: all ramp values wrap at DATA_WIDTH; the checksum wraps at 32 bits; cycle_count is 64-bit and does not saturate.

Decomposition:
- Package lake_harness_pkg:
  - state_t enum (IDLE/FLUSH/RUN/DONE)
  - CHK_WIDTH=32 constant
  - chan_slice helper function for packed per-channel buses
- Sub-module lake_capture_buf:
  - One instance per output channel.
  - DEPTH x DATA_WIDTH, one write port, one read-first registered read port.
- Top level holds the FSM, ramp accumulators, counters and the readback mux.

Test Plan:
- Loopback port_in->port_out, NUM_IN=NUM_OUT=1, start=0, stride=2, N=1000:
  - buf[k]=2k mod 2^16 for k<1000
  - checksum=999000
  - cycle_count=1000, done=1, overflow=0
- flush timing, FLUSH_CYCLES=4, start pulse at cycle t:
  - flush high at cycles t+1..t+4 only
  - first RUN stimulus at t+5
- N=0: FLUSH then DONE directly; cycle_count=0; checksum=0; no buffer writes.
- DEPTH=16, N=20, loopback stride=1:
  - buf[0..15]=0..15, overflow=1
  - checksum=190
  - rd_addr=16 returns 0
- rst asserted at RUN cycle 5 of N=10:
  - IDLE, outputs 0, flush=0
  - buf[0..4] readable with prior values
  - new start runs cleanly
- NUM_IN=NUM_OUT=2, stride {1, 0xFFFF}, start {0xFFFE,3}, N=4:
  - ch0 sequence FFFE,FFFF,0000,0001
  - ch1 sequence 3,2,1,0
  - start pulse during RUN ignored
